// File: rtl/miner_core_hash_engine.sv
`default_nettype none
// ============================================================================
// Module      : miner_core_hash_engine
// Description : SHA-256 single-block hash engine. Combines the message schedule
//               and compression in one datapath, using a rolling 16-word W
//               window. It has a start/busy/done handshake, an optional
//               chaining-value feed-forward, and processes RPC rounds per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module miner_core_hash_engine #(
    parameter int RPC      = 1,   // rounds per clock: 1, 2, 4 or 8
    parameter int FEED_FWD = 1    // 1: add chaining value to the final state
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [511:0] chunk,
    input  logic [255:0] init_h,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    // The round counter is 7 bits wide so that t+RPC never aliases before
    // the last-round compare.
    localparam logic [6:0] C_LAST_T = 7'(64 - RPC);
    localparam logic [6:0] C_STEP   = 7'(RPC);

    localparam logic [0:63][31:0] C_K_ROM = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [511:0]  r_chunk;
    logic [255:0]  r_init;
    logic [31:0]   r_win [0:15];     // r_win[0] holds W[t]
    logic [31:0]   r_wk  [0:7];      // working registers a..h, index 0 = a
    logic [6:0]    r_t;
    logic          r_done;
    logic [255:0]  r_digest;

    logic [31:0]   w_ext [0:15+RPC]; // window plus the RPC newly scheduled words
    logic [31:0]   w_st  [0:7];      // working state after RPC rounds
    logic [31:0]   w_t1;
    logic [31:0]   w_t2;
    logic [255:0]  w_final;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    assign ready  = (state == S_IDLE);
    assign busy   = (state != S_IDLE);
    assign done   = r_done;
    assign digest = r_digest;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> LOAD -> ROUND (64/RPC clocks) -> FINAL -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  next_state = S_ROUND;
            S_ROUND: if (r_t == C_LAST_T) next_state = S_FINAL;
            S_FINAL: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Schedule RPC new words and run RPC chained compression rounds.
    always_comb begin
        w_t1 = '0;
        w_t2 = '0;
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_win[i];
        end
        for (int j = 0; j < RPC; j++) begin
            w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
        end
        for (int i = 0; i < 8; i++) begin
            w_st[i] = r_wk[i];
        end
        for (int j = 0; j < RPC; j++) begin
            w_t1 = w_st[7] + bsig1(w_st[4]) + ch(w_st[4], w_st[5], w_st[6])
                 + C_K_ROM[r_t[5:0] + 6'(j)] + w_ext[j];
            w_t2 = bsig0(w_st[0]) + maj(w_st[0], w_st[1], w_st[2]);
            w_st[7] = w_st[6];
            w_st[6] = w_st[5];
            w_st[5] = w_st[4];
            w_st[4] = w_st[3] + w_t1;
            w_st[3] = w_st[2];
            w_st[2] = w_st[1];
            w_st[1] = w_st[0];
            w_st[0] = w_t1 + w_t2;
        end
    end

    generate
        if (FEED_FWD != 0) begin : g_feed_fwd
            // Final digest: post-round state plus the captured chaining value.
            always_comb begin
                w_final = '0;
                for (int i = 0; i < 8; i++) begin
                    w_final[255-32*i -: 32] = r_wk[i] + r_init[255-32*i -: 32];
                end
            end
        end else begin : g_raw_state
            // Final digest: raw post-round state.
            always_comb begin
                w_final = '0;
                for (int i = 0; i < 8; i++) begin
                    w_final[255-32*i -: 32] = r_wk[i];
                end
            end
        end
    endgenerate

    // Datapath registers: input capture, window/working-state update, digest.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_chunk  <= '0;
            r_init   <= '0;
            r_t      <= '0;
            r_done   <= 1'b0;
            r_digest <= '0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
            for (int i = 0; i < 8; i++)  r_wk[i]  <= '0;
        end else begin
            r_done <= (state == S_FINAL);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_chunk <= chunk;
                        r_init  <= init_h;
                    end
                end
                S_LOAD: begin
                    r_t <= '0;
                    for (int i = 0; i < 16; i++) r_win[i] <= r_chunk[511-32*i -: 32];
                    for (int i = 0; i < 8; i++)  r_wk[i]  <= r_init[255-32*i -: 32];
                end
                S_ROUND: begin
                    r_t <= r_t + C_STEP;
                    for (int i = 0; i < 16; i++) r_win[i] <= w_ext[i+RPC];
                    for (int i = 0; i < 8; i++)  r_wk[i]  <= w_st[i];
                end
                S_FINAL: begin
                    r_digest <= w_final;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
